// File: rtl/jtag_tap_target.sv
// jtag_tap_target: oversampled JTAG TAP responder with BYPASS, IDCODE and a USER data register.
// TCK/TMS/TDI are synchronized to CLK and all TAP actions occur on detected TCK edges.
module jtag_tap_target #(
    parameter int                IR_LEN      = 4,
    parameter logic [31:0]       IDCODE      = 32'h1BA0_0477,
    parameter logic [IR_LEN-1:0] IDCODE_INST = 4'b1110,
    parameter logic [IR_LEN-1:0] USER_INST   = 4'b1000,
    parameter int                USER_DR_LEN = 64
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   TCK,
    input  logic                   TMS,
    input  logic                   TDI,
    output logic                   TDO,
    output logic                   TDO_OE,
    input  logic [USER_DR_LEN-1:0] USER_CAPTURE,
    output logic [USER_DR_LEN-1:0] USER_UPDATE,
    output logic                   USER_UPDATE_STB,
    output logic                   USER_CAPTURE_STB,
    output logic [3:0]             TAP_STATE,
    output logic [IR_LEN-1:0]      IR
);
    localparam int SR_LEN = (USER_DR_LEN > 32) ? USER_DR_LEN : 32;

    typedef enum logic [3:0] {
        RTI    = 4'b0000, SEL_DR = 4'b0001, SH_DR  = 4'b0010, UP_DR  = 4'b0011,
        CAP_DR = 4'b0100, EX1_DR = 4'b0101, PA_DR  = 4'b0110, EX2_DR = 4'b0111,
        TLR    = 4'b1000, SEL_IR = 4'b1001, SH_IR  = 4'b1010, UP_IR  = 4'b1011,
        CAP_IR = 4'b1100, EX1_IR = 4'b1101, PA_IR  = 4'b1110, EX2_IR = 4'b1111
    } state_t;

    state_t                   r_state, w_next;
    logic [2:0]               r_tck_s;
    logic [1:0]               r_tms_s, r_tdi_s;
    logic [IR_LEN-1:0]        r_ir;
    logic [SR_LEN-1:0]        r_sr, w_sr_next, w_msb;
    logic [USER_DR_LEN-1:0]   r_user_upd;
    logic                     r_tdo, r_tdo_oe, r_cap_stb, r_upd_stb;
    logic                     w_tck_rise, w_tck_fall, w_tms, w_tdi;
    logic                     w_sel_id, w_sel_user, w_shifting;
    logic [31:0]              w_len;

    assign w_tck_rise = r_tck_s[1] & ~r_tck_s[2];
    assign w_tck_fall = ~r_tck_s[1] & r_tck_s[2];
    assign w_tms      = r_tms_s[1];
    assign w_tdi      = r_tdi_s[1];
    assign w_sel_id   = r_ir == IDCODE_INST;
    assign w_sel_user = r_ir == USER_INST;
    assign w_shifting = r_state == SH_DR || r_state == SH_IR;
    assign w_len      = (r_state == SH_IR) ? IR_LEN : w_sel_id ? 32'd32 : w_sel_user ? USER_DR_LEN : 32'd1;
    assign w_msb      = SR_LEN'(1) << (w_len - 32'd1);

    // Shift right within the selected length; TDI enters at that length's MSB.
    assign w_sr_next = (r_state == CAP_IR) ? SR_LEN'(2'b01) :
                       (r_state == CAP_DR) ? (w_sel_id ? SR_LEN'(IDCODE) : w_sel_user ? SR_LEN'(USER_CAPTURE) : '0) :
                       w_shifting ? (({1'b0, r_sr[SR_LEN-1:1]} & ~w_msb) | ({SR_LEN{w_tdi}} & w_msb)) : r_sr;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            r_state <= TLR;
        else if (w_tck_rise)
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            TLR:            w_next = w_tms ? TLR    : RTI;
            RTI:            w_next = w_tms ? SEL_DR : RTI;
            SEL_DR:         w_next = w_tms ? SEL_IR : CAP_DR;
            SEL_IR:         w_next = w_tms ? TLR    : CAP_IR;
            CAP_DR, SH_DR:  w_next = w_tms ? EX1_DR : SH_DR;
            EX1_DR:         w_next = w_tms ? UP_DR  : PA_DR;
            PA_DR:          w_next = w_tms ? EX2_DR : PA_DR;
            EX2_DR:         w_next = w_tms ? UP_DR  : SH_DR;
            CAP_IR, SH_IR:  w_next = w_tms ? EX1_IR : SH_IR;
            EX1_IR:         w_next = w_tms ? UP_IR  : PA_IR;
            PA_IR:          w_next = w_tms ? EX2_IR : PA_IR;
            EX2_IR:         w_next = w_tms ? UP_IR  : SH_IR;
            UP_DR, UP_IR:   w_next = w_tms ? SEL_DR : RTI;
            default:        w_next = TLR;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_tck_s    <= '0;
            r_tms_s    <= '0;
            r_tdi_s    <= '0;
            r_ir       <= IDCODE_INST;
            r_sr       <= '0;
            r_user_upd <= '0;
            r_tdo      <= 1'b0;
            r_tdo_oe   <= 1'b0;
            r_cap_stb  <= 1'b0;
            r_upd_stb  <= 1'b0;
        end else begin
            r_tck_s   <= {r_tck_s[1:0], TCK};
            r_tms_s   <= {r_tms_s[0], TMS};
            r_tdi_s   <= {r_tdi_s[0], TDI};
            r_cap_stb <= w_tck_rise && r_state == CAP_DR && w_sel_user;
            r_upd_stb <= w_tck_rise && r_state == UP_DR && w_sel_user;
            if (w_tck_rise) begin
                r_sr <= w_sr_next;
                // IR is also reset on entry so it is already IDCODE once LOGIC_RESET is reached.
                if (r_state == TLR || w_next == TLR)
                    r_ir <= IDCODE_INST;
                else if (r_state == UP_IR)
                    r_ir <= r_sr[IR_LEN-1:0];
                if (r_state == UP_DR && w_sel_user)
                    r_user_upd <= r_sr[USER_DR_LEN-1:0];
            end
            if (w_tck_fall) begin
                r_tdo_oe <= w_shifting;
                if (w_shifting)
                    r_tdo <= r_sr[0];
            end
        end
    end

    assign TDO              = r_tdo;
    assign TDO_OE           = r_tdo_oe;
    assign USER_UPDATE      = r_user_upd;
    assign USER_UPDATE_STB  = r_upd_stb;
    assign USER_CAPTURE_STB = r_cap_stb;
    assign TAP_STATE        = r_state;
    assign IR               = r_ir;
endmodule

// File: tb/tb_jtag_tap_target.sv
// tb_jtag_tap_target: directed TAP sequences with hand-computed expectations and immediate assertions.
module tb_jtag_tap_target;
    logic        CLK = 1'b0, RESET = 1'b1, TCK = 1'b0, TMS = 1'b0, TDI = 1'b0;
    logic        TDO, TDO_OE, USER_UPDATE_STB, USER_CAPTURE_STB;
    logic [63:0] USER_CAPTURE = 64'hDEAD_BEEF_0123_4567;
    logic [63:0] USER_UPDATE;
    logic [3:0]  TAP_STATE, IR;
    int          n_chk = 0, n_fail = 0, n_cap = 0, n_upd = 0;

    always #5 CLK = ~CLK;

    jtag_tap_target dut (
        .CLK(CLK), .RESET(RESET), .TCK(TCK), .TMS(TMS), .TDI(TDI),
        .TDO(TDO), .TDO_OE(TDO_OE),
        .USER_CAPTURE(USER_CAPTURE), .USER_UPDATE(USER_UPDATE),
        .USER_UPDATE_STB(USER_UPDATE_STB), .USER_CAPTURE_STB(USER_CAPTURE_STB),
        .TAP_STATE(TAP_STATE), .IR(IR)
    );

    // Counts strobe-high cycles, so a stretched pulse shows up as an extra count.
    always @(posedge CLK) begin
        if (USER_CAPTURE_STB) n_cap <= n_cap + 1;
        if (USER_UPDATE_STB) n_upd <= n_upd + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One TCK period of 8 CLK; TDO is sampled late in the low phase, just before the rise.
    task automatic tck(input logic tms, input logic tdi, output logic tdo, output logic oe);
        TMS = tms;
        TDI = tdi;
        repeat (4) @(negedge CLK);
        tdo = TDO;
        oe  = TDO_OE;
        TCK = 1'b1;
        repeat (4) @(negedge CLK);
        TCK = 1'b0;
    endtask

    task automatic step(input logic tms);
        logic a, b;
        tck(tms, 1'b0, a, b);
    endtask

    // From RUNTEST_IDLE: scan n bits LSB first through IR or DR and return to RUNTEST_IDLE.
    task automatic scan(input logic ir, input logic [63:0] din, input int n, output logic [63:0] dout, output int oes);
        logic b, oe;
        dout = '0;
        oes  = 0;
        step(1'b1);
        if (ir) step(1'b1);
        step(1'b0);
        step(1'b0);
        for (int i = 0; i < n; i++) begin
            tck(i == n - 1, din[i], b, oe);
            dout[i] = b;
            oes += int'(oe);
        end
        step(1'b1);
        step(1'b0);
    endtask

    initial begin
        logic [63:0] d;
        int          oes, cap0, upd0;
        logic        t, oe;

        repeat (5) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check("rst_state", 64'(TAP_STATE), 64'h8);
        check("rst_ir", 64'(IR), 64'hE);
        check("rst_oe", 64'(TDO_OE), 64'h0);
        check("rst_tdo", 64'(TDO), 64'h0);
        check("rst_cap_stb", 64'(USER_CAPTURE_STB), 64'h0);
        check("rst_upd_stb", 64'(USER_UPDATE_STB), 64'h0);
        check("rst_user_upd", USER_UPDATE, 64'h0);

        step(1'b0);
        check("rti", 64'(TAP_STATE), 64'h0);
        scan(1'b0, 64'h0, 32, d, oes);
        check("idcode", d, 64'h1BA0_0477);
        check("idcode_oe", 64'(oes), 64'd32);
        check("idcode_end_rti", 64'(TAP_STATE), 64'h0);

        scan(1'b1, 64'hF, 4, d, oes);
        check("ir_capture_bits", d, 64'h1);
        check("ir_oe", 64'(oes), 64'd4);
        check("ir_1111", 64'(IR), 64'hF);
        scan(1'b0, 64'h0A5, 9, d, oes);
        check("bypass_a5", d, 64'h14A);

        scan(1'b1, 64'h8, 4, d, oes);
        check("ir_user", 64'(IR), 64'h8);
        check("user_upd_before", USER_UPDATE, 64'h0);
        cap0 = n_cap;
        upd0 = n_upd;
        scan(1'b0, 64'h0F0F_0F0F_F0F0_F0F0, 64, d, oes);
        check("user_capture", d, 64'hDEAD_BEEF_0123_4567);
        check("user_oe", 64'(oes), 64'd64);
        check("user_cap_stb", 64'(n_cap - cap0), 64'd1);
        check("user_upd_stb", 64'(n_upd - upd0), 64'd1);
        check("user_update", USER_UPDATE, 64'h0F0F_0F0F_F0F0_F0F0);

        step(1'b1);
        step(1'b1);
        step(1'b0);
        check("cap_ir_state", 64'(TAP_STATE), 64'hC);
        step(1'b0);
        check("sh_ir_state", 64'(TAP_STATE), 64'hA);
        tck(1'b0, 1'b0, t, oe);
        check("ir_tdo_first", 64'(t), 64'h1);
        check("ir_tdo_oe", 64'(oe), 64'h1);
        tck(1'b1, 1'b1, t, oe);
        check("ir_tdo_second", 64'(t), 64'h0);
        step(1'b0);
        check("pause_ir", 64'(TAP_STATE), 64'hE);
        step(1'b0);
        step(1'b1);
        check("exit2_ir", 64'(TAP_STATE), 64'hF);
        step(1'b0);
        check("reshift_ir", 64'(TAP_STATE), 64'hA);
        tck(1'b0, 1'b1, t, oe);
        tck(1'b1, 1'b0, t, oe);
        step(1'b1);
        step(1'b0);
        check("ir_after_pause", 64'(IR), 64'h6);

        upd0 = n_upd;
        step(1'b1);
        step(1'b0);
        step(1'b0);
        check("sh_dr_state", 64'(TAP_STATE), 64'h2);
        tck(1'b0, 1'b1, t, oe);
        tck(1'b0, 1'b1, t, oe);
        repeat (4) step(1'b1);
        check("four_tms_sel_ir", 64'(TAP_STATE), 64'h9);
        check("four_tms_ir_kept", 64'(IR), 64'h6);
        step(1'b1);
        check("five_tms_tlr", 64'(TAP_STATE), 64'h8);
        check("five_tms_ir", 64'(IR), 64'hE);
        check("five_tms_no_upd", 64'(n_upd - upd0), 64'd0);
        check("five_tms_user_upd", USER_UPDATE, 64'h0F0F_0F0F_F0F0_F0F0);

        step(1'b0);
        scan(1'b1, 64'h8, 4, d, oes);
        upd0 = n_upd;
        step(1'b1);
        step(1'b0);
        step(1'b0);
        tck(1'b0, 1'b0, t, oe);
        tck(1'b0, 1'b1, t, oe);
        check("mid_shift_oe", 64'(TDO_OE), 64'h1);
        check("mid_shift_tdo", 64'(TDO), 64'h1);
        RESET = 1'b1;
        #1;
        check("async_rst_state", 64'(TAP_STATE), 64'h8);
        check("async_rst_ir", 64'(IR), 64'hE);
        check("async_rst_oe", 64'(TDO_OE), 64'h0);
        check("async_rst_tdo", 64'(TDO), 64'h0);
        check("async_rst_user_upd", USER_UPDATE, 64'h0);
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        check("async_rst_no_upd", 64'(n_upd - upd0), 64'd0);

        step(1'b0);
        scan(1'b0, 64'h0, 32, d, oes);
        check("idcode_after_rst", d, 64'h1BA0_0477);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
